tug_of_war_ctrl: RTL and testbench

TUG_OF_WAR_CTRL -- requirements
Module: tug_of_war_ctrl

---
 rtl/tug_of_war_ctrl.sv | 97 +++++++++
 tb/tb_tug_of_war_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tug_of_war_ctrl.sv
// tug_of_war_ctrl: two-key tug-of-war referee with key synchronisers, per-round win hold and match scoring.
module tug_of_war_ctrl #(
    parameter int HOLD_CYCLES = 8,
    parameter int SCORE_MAX   = 7
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       key_l_i,
    input  logic       key_r_i,
    input  logic [8:0] lights_i,
    output logic       move_l_o,
    output logic       move_r_o,
    output logic       field_reset_o,
    output logic [2:0] score_l_o,
    output logic [2:0] score_r_o,
    output logic       winner_l_o,
    output logic       winner_r_o,
    output logic       game_over_o
);
    typedef enum logic [2:0] {PLAY, WIN_L, WIN_R, RESTART, OVER} state_e;
    state_e     state_q, state_d;
    logic [2:0] sync_l_q, sync_r_q;
    logic [7:0] hold_q, hold_d;
    logic [2:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic       move_l_q, move_l_d, move_r_q, move_r_d, field_reset_q;
    logic       ev_l, ev_r, won_max;
    // bits [1:0] synchronise the key, bit [2] remembers the previous synchronised sample
    assign ev_l    = sync_l_q[1] & ~sync_l_q[2];
    assign ev_r    = sync_r_q[1] & ~sync_r_q[2];
    assign won_max = (state_q == WIN_L) ? (score_l_q == 3'(SCORE_MAX)) : (score_r_q == 3'(SCORE_MAX));
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= PLAY;
            sync_l_q      <= '0;
            sync_r_q      <= '0;
            hold_q        <= '0;
            score_l_q     <= '0;
            score_r_q     <= '0;
            move_l_q      <= 1'b0;
            move_r_q      <= 1'b0;
            field_reset_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            sync_l_q      <= {sync_l_q[1:0], key_l_i};
            sync_r_q      <= {sync_r_q[1:0], key_r_i};
            hold_q        <= hold_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            move_l_q      <= move_l_d;
            move_r_q      <= move_r_d;
            field_reset_q <= (state_d == RESTART);
        end
    end
    always_comb begin
        state_d   = state_q;
        hold_d    = '0;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        move_l_d  = 1'b0;
        move_r_d  = 1'b0;
        case (state_q)
            PLAY: begin
                if (ev_l && !ev_r) begin
                    if (lights_i[8]) begin
                        state_d = WIN_L;
                        if (score_l_q != 3'(SCORE_MAX)) score_l_d = score_l_q + 3'd1;
                    end else begin
                        move_l_d = 1'b1;
                    end
                end
                if (ev_r && !ev_l) begin
                    if (lights_i[0]) begin
                        state_d = WIN_R;
                        if (score_r_q != 3'(SCORE_MAX)) score_r_d = score_r_q + 3'd1;
                    end else begin
                        move_r_d = 1'b1;
                    end
                end
            end
            WIN_L, WIN_R: begin
                if (hold_q == 8'(HOLD_CYCLES - 1)) state_d = won_max ? OVER : RESTART;
                else hold_d = hold_q + 8'd1;
            end
            RESTART: state_d = PLAY;
            OVER:    state_d = OVER;
            default: state_d = RESTART;
        endcase
    end
    assign move_l_o      = move_l_q;
    assign move_r_o      = move_r_q;
    assign field_reset_o = field_reset_q;
    assign score_l_o     = score_l_q;
    assign score_r_o     = score_r_q;
    assign game_over_o   = (state_q == OVER);
    assign winner_l_o    = (state_q == WIN_L) || (state_q == OVER && score_l_q == 3'(SCORE_MAX));
    assign winner_r_o    = (state_q == WIN_R) || (state_q == OVER && score_r_q == 3'(SCORE_MAX));
endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// tb_tug_of_war_ctrl: directed stimulus against a cycle-level behavioural model of the referee rules.
module tb_tug_of_war_ctrl;
    localparam int HOLD = 8;
    localparam int SMAX = 7;
    logic       clk = 1'b0, rst_n = 1'b0, key_l = 1'b0, key_r = 1'b0;
    logic [8:0] lights = 9'b000010000;
    logic       move_l, move_r, field_reset, winner_l, winner_r, game_over;
    logic [2:0] score_l, score_r;
    int n_cmp = 0, n_bad = 0;
    int c_mvl = 0, c_mvr = 0, c_wl = 0, c_fr = 0;
    int b_mvl, b_mvr, b_wl, b_fr;

    tug_of_war_ctrl #(.HOLD_CYCLES(HOLD), .SCORE_MAX(SMAX)) dut (
        .clk_i(clk), .rst_ni(rst_n), .key_l_i(key_l), .key_r_i(key_r), .lights_i(lights),
        .move_l_o(move_l), .move_r_o(move_r), .field_reset_o(field_reset),
        .score_l_o(score_l), .score_r_o(score_r), .winner_l_o(winner_l),
        .winner_r_o(winner_r), .game_over_o(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: phase 0=play 1=win hold 2=restart 3=over; side 0=left 1=right
    bit ql[$], qr[$];
    int ph, side, hold, m_sl, m_sr, n;
    bit m_mvl, m_mvr, m_fr, el, er;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ql.delete(); qr.delete();
            ph = 0; side = 0; hold = 0; m_sl = 0; m_sr = 0;
            m_mvl = 0; m_mvr = 0; m_fr = 1;
        end else begin
            n  = ql.size();
            el = (n >= 2) && ql[n-2] && !((n >= 3) && ql[n-3]);
            er = (n >= 2) && qr[n-2] && !((n >= 3) && qr[n-3]);
            ql.push_back(key_l); qr.push_back(key_r);
            m_mvl = 0; m_mvr = 0; m_fr = 0;
            if (ph == 0 && el != er) begin
                if (el) begin
                    if (lights[8]) begin ph = 1; side = 0; hold = 0; if (m_sl < SMAX) m_sl++; end
                    else m_mvl = 1;
                end else begin
                    if (lights[0]) begin ph = 1; side = 1; hold = 0; if (m_sr < SMAX) m_sr++; end
                    else m_mvr = 1;
                end
            end else if (ph == 1) begin
                hold++;
                if (hold == HOLD) begin
                    ph   = (((side == 1) ? m_sr : m_sl) == SMAX) ? 3 : 2;
                    m_fr = (ph == 2);
                end
            end else if (ph == 2) begin
                ph = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("move_l", int'(move_l), int'(m_mvl));
        chk("move_r", int'(move_r), int'(m_mvr));
        chk("field_reset", int'(field_reset), int'(m_fr));
        chk("score_l", int'(score_l), m_sl);
        chk("score_r", int'(score_r), m_sr);
        chk("winner_l", int'(winner_l), int'((ph == 1 || ph == 3) && side == 0));
        chk("winner_r", int'(winner_r), int'((ph == 1 || ph == 3) && side == 1));
        chk("game_over", int'(game_over), int'(ph == 3));
        c_mvl += int'(move_l);
        c_mvr += int'(move_r);
        c_wl  += int'(winner_l);
        c_fr  += int'(field_reset);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic snap();
        b_mvl = c_mvl; b_mvr = c_mvr; b_wl = c_wl; b_fr = c_fr;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_field_reset", int'(field_reset), 1);
        chk("rst_score_l", int'(score_l), 0);
        chk("rst_game_over", int'(game_over), 0);
        rst_n = 1'b1;
        chk("release_hold_fr", int'(field_reset), 1);
        tick();
        chk("release_fr_drop", int'(field_reset), 0);
        // single short press, centre lit: move_l right after edge k+2
        snap();
        key_l = 1'b1;
        tick();
        tick();
        chk("mvl_before_k2", int'(move_l), 0);
        tick();
        key_l = 1'b0;
        chk("mvl_at_k2", int'(move_l), 1);
        repeat (5) tick();
        chk("mvl_one_pulse", c_mvl - b_mvl, 1);
        chk("mvr_none", c_mvr - b_mvr, 0);
        // held key gives a single event
        snap();
        key_l = 1'b1;
        repeat (20) tick();
        key_l = 1'b0;
        repeat (4) tick();
        chk("held_one_pulse", c_mvl - b_mvl, 1);
        // simultaneous presses cancel
        snap();
        key_l = 1'b1; key_r = 1'b1;
        repeat (3) tick();
        key_l = 1'b0; key_r = 1'b0;
        repeat (4) tick();
        chk("tie_no_mvl", c_mvl - b_mvl, 0);
        chk("tie_no_mvr", c_mvr - b_mvr, 0);
        chk("tie_no_win", int'(winner_l | winner_r), 0);
        // left round win: 8 cycles of winner_l, one restart cycle
        lights = 9'b100000000;
        snap();
        key_l = 1'b1;
        tick();
        key_l = 1'b0;
        repeat (15) tick();
        chk("win_score_l", int'(score_l), 1);
        chk("win_hold_len", c_wl - b_wl, 8);
        chk("win_fr_len", c_fr - b_fr, 1);
        chk("win_no_mvl", c_mvl - b_mvl, 0);
        chk("win_cleared", int'(winner_l), 0);
        // full match to SCORE_MAX from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < SMAX; i++) begin
            key_l = 1'b1;
            tick();
            key_l = 1'b0;
            repeat (14) tick();
        end
        chk("match_score_l", int'(score_l), 7);
        chk("match_over", int'(game_over), 1);
        chk("match_winner_l", int'(winner_l), 1);
        snap();
        key_l = 1'b1;
        tick();
        key_l = 1'b0;
        repeat (10) tick();
        chk("over_frozen", int'(score_l), 7);
        chk("over_no_mvl", c_mvl - b_mvl, 0);
        rst_n = 1'b0;
        #1;
        chk("over_rst_score", int'(score_l), 0);
        chk("over_rst_go", int'(game_over), 0);
        chk("over_rst_wl", int'(winner_l), 0);
        chk("over_rst_fr", int'(field_reset), 1);
        tick();
        rst_n = 1'b1;
        tick();
        // right win with both end lights lit, then reset mid-hold
        lights = 9'b100000001;
        key_r = 1'b1;
        tick();
        key_r = 1'b0;
        repeat (5) tick();
        chk("r_hold_winner", int'(winner_r), 1);
        chk("r_score_r", int'(score_r), 1);
        chk("r_score_l", int'(score_l), 0);
        rst_n = 1'b0;
        #1;
        chk("midhold_score_r", int'(score_r), 0);
        chk("midhold_winner_r", int'(winner_r), 0);
        chk("midhold_fr", int'(field_reset), 1);
        tick();
        rst_n = 1'b1;
        chk("midhold_fr_held", int'(field_reset), 1);
        tick();
        chk("midhold_fr_drop", int'(field_reset), 0);
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
